alu_seq: RTL

- Sequential, parametrised successor to the combinational ALU datapath.
- Registers operands and results and runs valid/ready handshakes on both sides.
- Adds an iterative shift-add multiplier and a tag passthrough, so the execute stage can track multi-cycle operations in flight.
- Sits between operand fetch and writeback: one operation in flight, one result buffered.

---
 rtl/alu_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides, an iterative shift-add
// multiplier and an opaque tag carried from request to result.
module alu_seq #(
    parameter int REG_WIDTH = 16,
    parameter int TAG_WIDTH = 4,
    parameter bit MUL_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [REG_WIDTH-1:0] in_a,
    input  logic [REG_WIDTH-1:0] in_b,
    input  logic                 in_cin,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] out_result,
    output logic                 out_cout,
    output logic                 out_zero,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int CNT_W = $clog2(REG_WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_HOLD
    } state_t;

    state_t                 state_q,  state_d;
    logic [REG_WIDTH-1:0]   mul_a_q,  mul_a_d;
    logic [REG_WIDTH-1:0]   mul_b_q,  mul_b_d;
    logic [2*REG_WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [REG_WIDTH-1:0]   result_q, result_d;
    logic                   cout_q,   cout_d;
    logic                   zero_q,   zero_d;
    logic [TAG_WIDTH-1:0]   tag_q,    tag_d;

    logic [REG_WIDTH:0]     alu_wide;
    logic [REG_WIDTH-1:0]   alu_res;
    logic                   alu_cout;
    logic [2*REG_WIDTH-1:0] partial;
    logic                   accept;
    logic                   start_mul;

    // Ready depends on out_ready so a draining result and a new request share a cycle.
    assign in_ready  = reset_n & ((state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign start_mul = accept & (in_op == OP_MUL) & MUL_EN;

    // Single-cycle ops; MUL falls to the zero default, which is also the MUL_EN=0 result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        alu_wide = '0;
        alu_res  = '0;
        alu_cout = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_wide = {1'b0, in_a} + {1'b0, in_b} + {{REG_WIDTH{1'b0}}, in_cin};
                alu_res  = alu_wide[REG_WIDTH-1:0];
                alu_cout = alu_wide[REG_WIDTH];
            end
            OP_SUB: begin
                alu_wide = {1'b0, in_a} + {1'b0, ~in_b} + (REG_WIDTH+1)'(1);
                alu_res  = alu_wide[REG_WIDTH-1:0];
                alu_cout = alu_wide[REG_WIDTH];
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_NOT:  alu_res = ~in_a;
            OP_PASS: alu_res = in_b;
            default: alu_res = '0;
        endcase
    end

    assign partial = mul_b_q[cnt_q] ? ({{REG_WIDTH{1'b0}}, mul_a_q} << cnt_q) : '0;

    always_comb begin
        state_d  = state_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        tag_d    = tag_q;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if ((state_q == S_HOLD) && out_ready) state_d = S_IDLE;
                if (accept) begin
                    tag_d = in_tag;
                    if (start_mul) begin
                        mul_a_d = in_a;
                        mul_b_d = in_b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        result_d = alu_res;
                        cout_d   = alu_cout;
                        zero_d   = (alu_res == '0);
                        state_d  = S_HOLD;
                    end
                end
            end
            S_BUSY: begin
                acc_d = acc_q + partial;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(REG_WIDTH - 1)) begin
                    result_d = acc_d[REG_WIDTH-1:0];
                    cout_d   = |acc_d[2*REG_WIDTH-1:REG_WIDTH];
                    zero_d   = (acc_d[REG_WIDTH-1:0] == '0);
                    state_d  = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state, datapath included, is reset so an aborted MUL leaves nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            tag_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            tag_q    <= tag_d;
        end
    end

    assign out_valid  = (state_q == S_HOLD);
    assign out_result = result_q;
    assign out_cout   = cout_q;
    assign out_zero   = zero_q;
    assign out_tag    = tag_q;

endmodule
